// File: rtl/iob_stream_fifo_pkg.sv
// Shared register map, control bits and STATUS layout for the CPU <-> stream bridge.
package iob_stream_fifo_pkg;

  typedef enum logic [1:0] {
    REG_DATA_IN  = 2'd0,
    REG_DATA_OUT = 2'd1,
    REG_STATUS   = 2'd2,
    REG_CTRL     = 2'd3
  } reg_sel_e;

  localparam int unsigned CTRL_FLUSH_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;
  localparam int unsigned STATUS_W       = 24;
  localparam int unsigned LEVEL_FIELD_W  = 8;

  // Field order gives bit0 tx_full .. bit5 unf, [15:8] tx_level, [23:16] rx_level.
  typedef struct packed {
    logic [LEVEL_FIELD_W-1:0] rx_level;
    logic [LEVEL_FIELD_W-1:0] tx_level;
    logic [1:0]               rsvd;
    logic                     unf;
    logic                     ovf;
    logic                     rx_empty;
    logic                     rx_full;
    logic                     tx_empty;
    logic                     tx_full;
  } status_t;

  function automatic reg_sel_e decode_reg(input logic [1:0] word_addr);
    return reg_sel_e'(word_addr);
  endfunction

endpackage

// File: rtl/iob_stream_fifo_if.sv
// Native bus plus TX/RX stream signals of the bridge, grouped as one bundle.
interface iob_stream_fifo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);

  logic                  valid;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;

  logic [DATA_W-1:0]     tx_tdata;
  logic                  tx_tvalid;
  logic                  tx_tready;

  logic [DATA_W-1:0]     rx_tdata;
  logic                  rx_tvalid;
  logic                  rx_tready;

  // Peripheral side.
  modport slave (
    input  valid, address, wdata, wstrb, tx_tready, rx_tdata, rx_tvalid,
    output rdata, ready, tx_tdata, tx_tvalid, rx_tready
  );

  // System side: CPU bus master plus the accelerator.
  modport master (
    output valid, address, wdata, wstrb, tx_tready, rx_tdata, rx_tvalid,
    input  rdata, ready, tx_tdata, tx_tvalid, rx_tready
  );

endinterface

// File: rtl/iob_sync_fifo.sv
// Synchronous first-word-fall-through FIFO on a register array, with flush.
module iob_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_ok, pop_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign head  = mem_q[rptr_q];

  // Acceptance uses start-of-cycle flags; flush overrides both sides.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = wptr_q + ADDR_W'(1);
      end
      if (pop_ok) begin
        rptr_d = rptr_q + ADDR_W'(1);
      end
      level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage contents are don't-care until written, so no reset here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/iob_stream_fifo.sv
// CPU-facing bridge: bus decode, registered response, sticky flags, TX/RX FIFOs.
module iob_stream_fifo
  import iob_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned FIFO_ADDR_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  iob_stream_fifo_if.slave bus
);

  localparam int unsigned LVL_W = FIFO_ADDR_W + 1;

  logic [ADDR_W-1:0] addr_c;
  logic [1:0]        unused_addr_lsb_c;
  reg_sel_e          sel_c;
  logic              is_write_c;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              tx_push_c, tx_pop_c, rx_push_c, rx_pop_c, flush_c;
  logic              rx_tready_c;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic [LVL_W-1:0]  tx_level, rx_level;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  status_t           status_c;

  assign addr_c            = bus.address;
  assign unused_addr_lsb_c = addr_c[1:0];
  assign sel_c             = decode_reg(addr_c[3:2]);
  assign is_write_c        = |bus.wstrb;

  assign rx_tready_c = !rx_full && rst;
  assign tx_pop_c    = !tx_empty && bus.tx_tready;
  assign rx_push_c   = bus.rx_tvalid && rx_tready_c;

  assign bus.rdata     = rdata_q;
  assign bus.ready     = ready_q;
  assign bus.tx_tdata  = tx_head;
  assign bus.tx_tvalid = !tx_empty;
  assign bus.rx_tready = rx_tready_c;

  iob_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(FIFO_ADDR_W)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_c),
    .push      (tx_push_c),
    .push_data (bus.wdata),
    .pop       (tx_pop_c),
    .head      (tx_head),
    .level     (tx_level),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  iob_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(FIFO_ADDR_W)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_c),
    .push      (rx_push_c),
    .push_data (bus.rx_tdata),
    .pop       (rx_pop_c),
    .head      (rx_head),
    .level     (rx_level),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_comb begin
    status_c          = '0;
    status_c.tx_full  = tx_full;
    status_c.tx_empty = tx_empty;
    status_c.rx_full  = rx_full;
    status_c.rx_empty = rx_empty;
    status_c.ovf      = ovf_q;
    status_c.unf      = unf_q;
    status_c.tx_level = LEVEL_FIELD_W'(tx_level);
    status_c.rx_level = LEVEL_FIELD_W'(rx_level);
  end

  // Register decode; side effects land on the sampling edge, response one cycle later.
  always_comb begin
    rdata_d   = '0;
    ready_d   = bus.valid;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    tx_push_c = 1'b0;
    rx_pop_c  = 1'b0;
    flush_c   = 1'b0;
    if (bus.valid) begin
      unique case (sel_c)
        REG_DATA_IN: begin
          if (is_write_c) begin
            tx_push_c = 1'b1;
            if (tx_full) ovf_d = 1'b1;
          end
        end
        REG_DATA_OUT: begin
          if (!is_write_c) begin
            if (rx_empty) begin
              unf_d = 1'b1;
            end else begin
              rx_pop_c = 1'b1;
              rdata_d  = rx_head;
            end
          end
        end
        REG_STATUS: begin
          if (!is_write_c) rdata_d = DATA_W'(status_c);
        end
        REG_CTRL: begin
          if (is_write_c) begin
            flush_c = bus.wdata[CTRL_FLUSH_BIT];
            if (bus.wdata[CTRL_CLEAR_BIT]) begin
              ovf_d = 1'b0;
              unf_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_iob_stream_fifo.sv
// Directed plus randomized bench for iob_stream_fifo against a queue-based reference model.
module tb_iob_stream_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_drv = 1'b0;
  always #5 clk = ~clk;

  iob_stream_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  iob_stream_fifo #(.DATA_W(DW), .ADDR_W(AW), .FIFO_ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst_drv),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] mtx[$];
  logic [31:0] mrx[$];
  bit          movf, munf;
  bit          exp_ready;
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_of(input int txn, input int rxn, input bit o, input bit u);
    return (32'(rxn) << 16) | (32'(txn) << 8) | (32'(u) << 5) | (32'(o) << 4)
         | (32'(rxn == 0) << 3) | (32'(rxn == DEPTH) << 2)
         | (32'(txn == 0) << 1) | 32'(txn == DEPTH);
  endfunction

  // Model one clock from the currently driven inputs, then check outputs at the negedge.
  task automatic cyc();
    int          txn = mtx.size();
    int          rxn = mrx.size();
    bit          wr, flush;
    logic [1:0]  sel;
    logic [31:0] rxd;
    exp_ready = 1'b0;
    exp_rdata = '0;
    flush     = 1'b0;
    if (!rst_drv) begin
      mtx.delete();
      mrx.delete();
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      rxd = bus.rx_tdata;
      if (txn > 0 && bus.tx_tready) void'(mtx.pop_front());
      if (bus.valid) begin
        exp_ready = 1'b1;
        wr  = |bus.wstrb;
        sel = bus.address[3:2];
        case (sel)
          2'd0: if (wr) begin
            if (txn == DEPTH) movf = 1'b1;
            else mtx.push_back(bus.wdata);
          end
          2'd1: if (!wr) begin
            if (rxn == 0) munf = 1'b1;
            else exp_rdata = mrx.pop_front();
          end
          2'd2: if (!wr) exp_rdata = status_of(txn, rxn, movf, munf);
          default: if (wr) begin
            if (bus.wdata[1]) begin movf = 1'b0; munf = 1'b0; end
            flush = bus.wdata[0];
          end
        endcase
      end
      if (bus.rx_tvalid && rxn < DEPTH) mrx.push_back(rxd);
      if (flush) begin
        mtx.delete();
        mrx.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("ready", 32'(bus.ready), 32'(exp_ready));
    if (exp_ready) chk("rdata", bus.rdata, exp_rdata);
    chk("tx_tvalid", 32'(bus.tx_tvalid), 32'(mtx.size() != 0));
    if (mtx.size() != 0) chk("tx_tdata", bus.tx_tdata, mtx[0]);
    chk("rx_tready", 32'(bus.rx_tready), 32'(rst_drv && mrx.size() < DEPTH));
  endtask

  task automatic req(input logic [1:0] sel, input logic [31:0] wd, input logic [3:0] ws);
    bus.valid   = 1'b1;
    bus.address = {sel, 2'($urandom)};
    bus.wdata   = wd;
    bus.wstrb   = ws;
    cyc();
    bus.valid   = 1'b0;
    bus.wstrb   = '0;
    last_rdata  = bus.rdata;
  endtask

  task automatic access(input logic [1:0] sel, input logic [31:0] wd, input logic [3:0] ws);
    req(sel, wd, ws);
    cyc();
  endtask

  initial begin
    bit just_req;
    bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;
    bus.tx_tready = 1'b0; bus.rx_tvalid = 1'b0; bus.rx_tdata = '0;
    movf = 1'b0; munf = 1'b0;

    // Reset and first status read
    repeat (3) cyc();
    rst_drv = 1'b1;
    access(2'd2, 0, 4'h0);
    chk("reset_status", last_rdata, 32'h0000_000A);
    chk("reset_tx_tvalid", 32'(bus.tx_tvalid), 32'd0);
    chk("reset_rx_tready", 32'(bus.rx_tready), 32'd1);

    // TX fill and overflow, then drain
    for (int i = 0; i < 17; i++) access(2'd0, 32'h100 + 32'(i), 4'hF);
    access(2'd2, 0, 4'h0);
    chk("tx_full_status", last_rdata, 32'h0000_1019);
    bus.tx_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_drain_data", bus.tx_tdata, 32'h100 + 32'(i));
      cyc();
    end
    chk("tx_drained_valid", 32'(bus.tx_tvalid), 32'd0);
    bus.tx_tready = 1'b0;

    // RX pop, underflow and flag clear
    bus.rx_tvalid = 1'b1;
    bus.rx_tdata  = 32'hA5A5_0001; cyc();
    bus.rx_tdata  = 32'hA5A5_0002; cyc();
    bus.rx_tvalid = 1'b0;
    access(2'd1, 0, 4'h0); chk("rx_pop0", last_rdata, 32'hA5A5_0001);
    access(2'd1, 0, 4'h0); chk("rx_pop1", last_rdata, 32'hA5A5_0002);
    access(2'd1, 0, 4'h0); chk("rx_underflow", last_rdata, 32'h0);
    access(2'd2, 0, 4'h0); chk("flags_status", last_rdata, 32'h0000_003A);
    access(2'd3, 32'h2, 4'hF);
    access(2'd2, 0, 4'h0); chk("flags_cleared", last_rdata, 32'h0000_000A);

    // RX full back-pressure and release by one pop
    bus.rx_tvalid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.rx_tdata = 32'hB000_0000 + 32'(mrx.size());
      cyc();
    end
    chk("rx_full_tready", 32'(bus.rx_tready), 32'd0);
    bus.rx_tdata = 32'hB000_0010;
    req(2'd1, 0, 4'h0);
    chk("rx_full_pop", last_rdata, 32'hB000_0000);
    chk("rx_tready_after_pop", 32'(bus.rx_tready), 32'd1);
    cyc();
    chk("rx_17th_accepted", 32'(bus.rx_tready), 32'd0);
    bus.rx_tvalid = 1'b0;
    access(2'd2, 0, 4'h0); chk("rx_full_status", last_rdata, 32'h0010_0006);

    // Simultaneous TX push and pop at level 8
    for (int i = 0; i < 8; i++) access(2'd0, 32'h200 + 32'(i), 4'hF);
    bus.tx_tready = 1'b1;
    req(2'd0, 32'h208, 4'hF);
    bus.tx_tready = 1'b0;
    cyc();
    access(2'd2, 0, 4'h0); chk("tx_level_hold", last_rdata, 32'h0010_0804);

    // Flush colliding with an RX push
    access(2'd1, 0, 4'h0); chk("rx_pop_b1", last_rdata, 32'hB000_0001);
    access(2'd1, 0, 4'h0); chk("rx_pop_b2", last_rdata, 32'hB000_0002);
    bus.rx_tvalid = 1'b1;
    bus.rx_tdata  = 32'hC0DE_0001;
    req(2'd3, 32'h1, 4'hF);
    bus.rx_tvalid = 1'b0;
    cyc();
    access(2'd2, 0, 4'h0); chk("flush_status", last_rdata, 32'h0000_000A);

    // Reset colliding with a pending access
    access(2'd1, 0, 4'h0);
    access(2'd0, 32'h55, 4'hF);
    bus.valid = 1'b1; bus.address = 4'h8; bus.wstrb = '0;
    rst_drv = 1'b0;
    cyc();
    bus.valid = 1'b0;
    chk("rst_mid_ready", 32'(bus.ready), 32'd0);
    cyc(); cyc();
    rst_drv = 1'b1;
    cyc();
    access(2'd2, 0, 4'h0); chk("rst_mid_status", last_rdata, 32'h0000_000A);

    // Randomized traffic against the model
    just_req = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      bus.tx_tready = 1'($urandom_range(0, 2) == 0);
      bus.rx_tvalid = 1'($urandom_range(0, 2) != 0);
      bus.rx_tdata  = $urandom;
      if (!just_req && $urandom_range(0, 1) == 1) begin
        logic [1:0]  sel;
        logic [31:0] wd;
        logic [3:0]  ws;
        sel = 2'($urandom_range(0, 3));
        ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        wd  = $urandom;
        if (sel == 2'd3) wd = ($urandom_range(0, 7) == 0) ? 32'h1 : 32'($urandom_range(0, 3)) & 32'h2;
        if (sel == 2'd0 && $urandom_range(0, 1) == 1) ws = 4'hF;
        req(sel, wd, ws);
        just_req = 1'b1;
      end else begin
        cyc();
        just_req = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
